// File: rtl/sc_pwm_pkg.sv
// sc_pwm_pkg: shared state type and sizing helpers for the sc_pwm_driver H-bridge PWM block.
// Latency: none (declarations only).
// Backpressure: none.
package sc_pwm_pkg;

  // Driver states. BRAKE is only reachable when SC_PWM_BRAKE_EN is defined.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DEAD  = 2'd2,
    BRAKE = 2'd3
  } pwm_state_e;

  // Board default: 50 MHz / 250 = 200 kHz PWM tick.
  localparam int unsigned PWM_PRESCALE_DIV_DEF = 250;

  // Period length in ticks for an n-bit duty counter.
  function automatic int unsigned pwm_max(input int unsigned n_duty);
    return (32'd1 << n_duty) - 32'd1;
  endfunction

  // Width needed to hold 0..n-1, never below one bit (covers n == 1).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/sc_pwm_tick.sv
// sc_pwm_tick: clock-enable divider; tick_o is a one-clock strobe every DIV clocks while run_i is high.
// Latency: first tick DIV clocks after the clearing edge; tick_o is decoded from the count register.
// Backpressure: none; clr_i restarts the count at 0, run_i low holds it at 0.
//
// Ports:
//   clk_i   system clock (the only clock; tick_o is an enable, not a clock)
//   rst_ni  asynchronous active-low reset
//   run_i   count enable (driver outside IDLE)
//   clr_i   restart count at 0 on the next edge (state entry)
//   tick_o  one-clock pulse when the count sits at DIV-1
module sc_pwm_tick
  import sc_pwm_pkg::*;
#(
  parameter int unsigned DIV = PWM_PRESCALE_DIV_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned PRE_W = cnt_width(DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 32'd1);

  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;

  always_comb begin
    pre_d = pre_q;
    if (clr_i || !run_i) begin
      pre_d = '0;
    end else if (pre_q == PRE_LAST) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  // Not gated by clr_i: the FSM uses tick to decide state entry, and clr_i
  // is derived from that decision.
  assign tick_o = run_i && (pre_q == PRE_LAST);

endmodule

// File: rtl/sc_pwm_driver.sv
// sc_pwm_driver: one H-bridge channel; binary period counter PWM with shadow-loaded duty/dir and dead-time on reversal.
// Latency: outputs are registered and change on the clock edge that consumes a tick (one clock after the tick strobe).
// Backpressure: none; LOAD may be held low any number of clocks, the last captured value applies at the next boundary.
//
// Optional feature macro: SC_PWM_BRAKE_EN (adds SC_PWM_BRAKE_InLow and the BRAKE state).
//
// Ports:
//   SC_PWM_CLOCK_50       system clock, 50 MHz
//   SC_PWM_RESET_InLow    asynchronous active-low reset
//   SC_PWM_ENABLE_InLow   0 = run, 1 = idle (forces IDLE on the next clock)
//   SC_PWM_LOAD_InLow     0 = capture duty/dir into the pending registers
//   SC_PWM_DUTY_InBus     requested high time in ticks, 0..MAX
//   SC_PWM_DIR_In         0 = forward (OUT_A), 1 = reverse (OUT_B)
//   SC_PWM_BRAKE_InLow    (SC_PWM_BRAKE_EN only) 0 = short-brake request
//   SC_PWM_OUT_A/B        registered bridge inputs
//   SC_PWM_PERIOD_OutLow  one-clock low pulse at each period wrap in RUN
//   SC_PWM_BUSY_Out       high in DEAD (and BRAKE)
module sc_pwm_driver
  import sc_pwm_pkg::*;
#(
  parameter int unsigned N_DUTY         = 8,
  parameter int unsigned PREESCALE_DIV  = PWM_PRESCALE_DIV_DEF,
  parameter int unsigned DEADTIME_TICKS = 16
) (
  input  logic              SC_PWM_CLOCK_50,
  input  logic              SC_PWM_RESET_InLow,
  input  logic              SC_PWM_ENABLE_InLow,
  input  logic              SC_PWM_LOAD_InLow,
  input  logic [N_DUTY-1:0] SC_PWM_DUTY_InBus,
  input  logic              SC_PWM_DIR_In,
`ifdef SC_PWM_BRAKE_EN
  input  logic              SC_PWM_BRAKE_InLow,
`endif
  output logic              SC_PWM_OUT_A,
  output logic              SC_PWM_OUT_B,
  output logic              SC_PWM_PERIOD_OutLow,
  output logic              SC_PWM_BUSY_Out
);

  localparam logic [N_DUTY-1:0] CNT_LAST = N_DUTY'(pwm_max(N_DUTY) - 32'd1);
  localparam int unsigned       DT_W     = cnt_width(DEADTIME_TICKS);
  localparam logic [DT_W-1:0]   DT_LAST  = DT_W'(DEADTIME_TICKS - 32'd1);

  pwm_state_e        state_q, state_d;
  logic [N_DUTY-1:0] cnt_q, cnt_d;
  logic [N_DUTY-1:0] duty_q, duty_d;
  logic              dir_q, dir_d;
  logic [N_DUTY-1:0] pend_duty_q, pend_duty_d;
  logic              pend_dir_q, pend_dir_d;
  logic [DT_W-1:0]   dcnt_q, dcnt_d;
  logic              out_a_q, out_a_d;
  logic              out_b_q, out_b_d;
  logic              period_n_q, period_n_d;
  logic              busy_q, busy_d;
  logic              wrap;
  logic              pwm;
  logic              tick;
  logic              pre_run;
  logic              pre_clr;

`ifdef SC_PWM_BRAKE_EN
  logic brake_req;
  logic brk_on_q, brk_on_d;   // short-brake phase reached (both outputs high)
  assign brake_req = !SC_PWM_BRAKE_InLow;
`endif

  // Prescaler restarts on every state change so each state's first tick
  // lands exactly DIV clocks after entry.
  assign pre_run = (state_q != IDLE);
  assign pre_clr = (state_d != state_q);

  sc_pwm_tick #(
    .DIV (PREESCALE_DIV)
  ) u_tick (
    .clk_i  (SC_PWM_CLOCK_50),
    .rst_ni (SC_PWM_RESET_InLow),
    .run_i  (pre_run),
    .clr_i  (pre_clr),
    .tick_o (tick)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    duty_d      = duty_q;
    dir_d       = dir_q;
    dcnt_d      = dcnt_q;
    pend_duty_d = pend_duty_q;
    pend_dir_d  = pend_dir_q;
    wrap        = 1'b0;
`ifdef SC_PWM_BRAKE_EN
    brk_on_d    = brk_on_q;
`endif

    if (!SC_PWM_LOAD_InLow) begin
      pend_duty_d = SC_PWM_DUTY_InBus;
      pend_dir_d  = SC_PWM_DIR_In;
    end

    // Transitions below read pend_*_q: a LOAD on the same edge is applied
    // at the following boundary, never at this one.
    if (SC_PWM_ENABLE_InLow) begin
      state_d = IDLE;
      cnt_d   = '0;
      dcnt_d  = '0;
`ifdef SC_PWM_BRAKE_EN
      brk_on_d = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_d = RUN;
          cnt_d   = '0;
          duty_d  = pend_duty_q;
          dir_d   = pend_dir_q;
        end
        RUN: begin
`ifdef SC_PWM_BRAKE_EN
          if (brake_req) begin
            state_d  = BRAKE;
            dcnt_d   = '0;
            brk_on_d = 1'b0;
          end else
`endif
          if (tick) begin
            if (cnt_q == CNT_LAST) begin
              if (pend_dir_q != dir_q) begin
                state_d = DEAD;
                dcnt_d  = '0;
              end else begin
                cnt_d  = '0;
                duty_d = pend_duty_q;
                wrap   = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        DEAD: begin
`ifdef SC_PWM_BRAKE_EN
          if (brake_req) begin
            state_d  = BRAKE;
            dcnt_d   = '0;
            brk_on_d = 1'b0;
          end else
`endif
          if (tick) begin
            if (dcnt_q == DT_LAST) begin
              state_d = RUN;
              cnt_d   = '0;
              dcnt_d  = '0;
              duty_d  = pend_duty_q;
              dir_d   = pend_dir_q;
            end else begin
              dcnt_d = dcnt_q + 1'b1;
            end
          end
        end
        BRAKE: begin
`ifdef SC_PWM_BRAKE_EN
          if (!brake_req) begin
            // Release goes through a full dead-time before driving again.
            state_d  = DEAD;
            dcnt_d   = '0;
            brk_on_d = 1'b0;
          end else if (tick && !brk_on_q) begin
            if (dcnt_q == DT_LAST) begin
              brk_on_d = 1'b1;
              dcnt_d   = '0;
            end else begin
              dcnt_d = dcnt_q + 1'b1;
            end
          end
`else
          state_d = IDLE;
`endif
        end
        default: state_d = IDLE;
      endcase
    end

    // Outputs are computed from next-state values so the registered pins
    // move on the same edge as the counter.
    pwm     = (cnt_d < duty_d);
    out_a_d = (state_d == RUN) && pwm && !dir_d;
    out_b_d = (state_d == RUN) && pwm && dir_d;
`ifdef SC_PWM_BRAKE_EN
    if ((state_d == BRAKE) && brk_on_d) begin
      out_a_d = 1'b1;
      out_b_d = 1'b1;
    end
`endif
    busy_d     = (state_d == DEAD) || (state_d == BRAKE);
    period_n_d = !wrap;
  end

  always_ff @(posedge SC_PWM_CLOCK_50 or negedge SC_PWM_RESET_InLow) begin
    if (!SC_PWM_RESET_InLow) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      duty_q      <= '0;
      dir_q       <= 1'b0;
      pend_duty_q <= '0;
      pend_dir_q  <= 1'b0;
      dcnt_q      <= '0;
      out_a_q     <= 1'b0;
      out_b_q     <= 1'b0;
      period_n_q  <= 1'b1;
      busy_q      <= 1'b0;
`ifdef SC_PWM_BRAKE_EN
      brk_on_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      duty_q      <= duty_d;
      dir_q       <= dir_d;
      pend_duty_q <= pend_duty_d;
      pend_dir_q  <= pend_dir_d;
      dcnt_q      <= dcnt_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      period_n_q  <= period_n_d;
      busy_q      <= busy_d;
`ifdef SC_PWM_BRAKE_EN
      brk_on_q    <= brk_on_d;
`endif
    end
  end

  assign SC_PWM_OUT_A         = out_a_q;
  assign SC_PWM_OUT_B         = out_b_q;
  assign SC_PWM_PERIOD_OutLow = period_n_q;
  assign SC_PWM_BUSY_Out      = busy_q;

endmodule

// File: tb/tb_sc_pwm_driver.sv
// tb_sc_pwm_driver: bench for sc_pwm_driver with N_DUTY=4, PREESCALE_DIV=2, DEADTIME_TICKS=3.
// The reference tracks elapsed clocks since the start of each RUN/DEAD segment and derives pin levels from that.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_sc_pwm_driver;

  localparam int NDUTY = 4;
  localparam int DIV   = 2;
  localparam int DT    = 3;
  localparam int MAXV  = 15;
  localparam int PER   = MAXV * DIV;   // clocks per PWM period
  localparam int DEADC = DT * DIV;     // clocks of dead-time

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DEAD = 2;

  typedef struct packed {
    int mode;
    int k;       // clocks since this segment (period or dead-time) began
    int duty;
    int dir;
    int pduty;
    int pdir;
    bit wrap;
  } mdl_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en_n;
  logic             load_n;
  logic [NDUTY-1:0] duty_in;
  logic             dir;
  logic             out_a, out_b, per_n, busy;

  int   checks   = 0;
  int   failures = 0;
  bit   chk_on   = 1'b0;
  mdl_t m;

  always #5 clk = ~clk;

  sc_pwm_driver #(
    .N_DUTY         (NDUTY),
    .PREESCALE_DIV  (DIV),
    .DEADTIME_TICKS (DT)
  ) dut (
    .SC_PWM_CLOCK_50      (clk),
    .SC_PWM_RESET_InLow   (rst_n),
    .SC_PWM_ENABLE_InLow  (en_n),
    .SC_PWM_LOAD_InLow    (load_n),
    .SC_PWM_DUTY_InBus    (duty_in),
    .SC_PWM_DIR_In        (dir),
    .SC_PWM_OUT_A         (out_a),
    .SC_PWM_OUT_B         (out_b),
    .SC_PWM_PERIOD_OutLow (per_n),
    .SC_PWM_BUSY_Out      (busy)
  );

  // One clock of the behavioural model, given the inputs seen at that edge.
  function automatic mdl_t step(input mdl_t s, input logic en_n_i, input logic load_n_i,
                                input logic [NDUTY-1:0] duty_i, input logic dir_i);
    mdl_t n;
    n      = s;
    n.wrap = 1'b0;
    if (!load_n_i) begin
      n.pduty = int'(duty_i);
      n.pdir  = int'(dir_i);
    end
    if (en_n_i) begin
      n.mode = M_IDLE;
      n.k    = 0;
    end else if (s.mode == M_IDLE) begin
      n.mode = M_RUN;
      n.k    = 0;
      n.duty = s.pduty;
      n.dir  = s.pdir;
    end else if (s.mode == M_RUN) begin
      n.k = s.k + 1;
      if (n.k == PER) begin
        n.k = 0;
        if (s.pdir != s.dir) begin
          n.mode = M_DEAD;
        end else begin
          n.duty = s.pduty;
          n.wrap = 1'b1;
        end
      end
    end else begin
      n.k = s.k + 1;
      if (n.k == DEADC) begin
        n.mode = M_RUN;
        n.k    = 0;
        n.duty = s.pduty;
        n.dir  = s.pdir;
      end
    end
    return n;
  endfunction

  function automatic logic [3:0] exp_out(input mdl_t s);
    logic lvl;
    lvl = (s.mode == M_RUN) && ((s.k / DIV) < s.duty);
    return {lvl && (s.dir == 0), lvl && (s.dir == 1), !s.wrap, s.mode == M_DEAD};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= step(m, en_n, load_n, duty_in, dir);
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    logic [3:0] e;
    logic [3:0] a;
    if (chk_on) begin
      e = exp_out(m);
      a = {out_a, out_b, per_n, busy};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL cycle_cmp t=%0t {a,b,per_n,busy} got=%b want=%b mode=%0d k=%0d",
                 $time, a, e, m.mode, m.k);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int d, input int r);
    load_n  = 1'b0;
    duty_in = NDUTY'(d);
    dir     = r[0];
    @(negedge clk);
    load_n  = 1'b1;
  endtask

  task automatic measure(input int n, output int a_hi, output int b_hi,
                         output int per_lo, output int busy_hi);
    a_hi = 0; b_hi = 0; per_lo = 0; busy_hi = 0;
    repeat (n) begin
      @(negedge clk);
      a_hi    += (out_a === 1'b1) ? 1 : 0;
      b_hi    += (out_b === 1'b1) ? 1 : 0;
      per_lo  += (per_n === 1'b0) ? 1 : 0;
      busy_hi += (busy  === 1'b1) ? 1 : 0;
    end
  endtask

  task automatic wait_per(input string name);
    int i;
    bit ok;
    ok = 1'b0;
    i  = 0;
    while (!ok && i < 200) begin
      @(negedge clk);
      ok = (per_n === 1'b0);
      i++;
    end
    check(name, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_busy(input string name);
    int i;
    bit ok;
    ok = 1'b0;
    i  = 0;
    while (!ok && i < 200) begin
      @(negedge clk);
      ok = (busy === 1'b1);
      i++;
    end
    check(name, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b, p, bz, gap, r;
    rst_n = 1'b1; en_n = 1'b1; load_n = 1'b1; duty_in = '0; dir = 1'b0;

    // Reset with no clock edge in between.
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_a", {31'd0, out_a}, 0);
    check("rst_out_b", {31'd0, out_b}, 0);
    check("rst_per_n", {31'd0, per_n}, 1);
    check("rst_busy",  {31'd0, busy},  0);
    chk_on = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    @(negedge clk);

    // duty 5 forward: 10 of 30 clocks high, period every 30 clocks.
    load(5, 0);
    en_n = 1'b0;
    measure(30, a, b, p, bz);
    check("d5_a_hi", a, 10);
    check("d5_b_hi", b, 0);
    wait_per("d5_first_wrap");
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (per_n !== 1'b0 && gap < 200);
    check("d5_period_gap", gap, 30);

    // duty 0 and duty MAX: constant levels, period pulses continue.
    load(0, 0);
    wait_per("d0_wrap");
    measure(30, a, b, p, bz);
    check("d0_a_hi", a, 0);
    check("d0_per_lo", p, 1);
    load(15, 0);
    wait_per("d15_wrap");
    measure(30, a, b, p, bz);
    check("d15_a_hi", a, 30);
    check("d15_per_lo", p, 1);

    // Mid-period reversal: 6 dead clocks then OUT_B 16 of 30.
    cyc(3);
    load(8, 1);
    wait_busy("rev_dead_start");
    measure(5, a, b, p, bz);
    check("rev_busy_rest", bz, 5);
    check("rev_dead_outs", a + b, 0);
    measure(30, a, b, p, bz);
    check("rev_b_hi", b, 16);
    check("rev_a_hi", a, 0);
    check("rev_busy_after", bz, 0);

    // Load at the wrap-tick clock: old duty for one more period.
    wait_per("d12_sync");
    cyc(29);
    load_n = 1'b0; duty_in = 4'd12; dir = 1'b1;
    @(negedge clk);
    load_n = 1'b1;
    measure(29, a, b, p, bz);
    check("d12_old_b_hi", b, 15);
    measure(30, a, b, p, bz);
    check("d12_new_b_hi", b, 24);

    // Dir change together with disable: no dead-time on re-enable.
    load_n = 1'b0; duty_in = 4'd12; dir = 1'b0; en_n = 1'b1;
    @(negedge clk);
    load_n = 1'b1;
    cyc(2);
    en_n = 1'b0;
    measure(30, a, b, p, bz);
    check("reen_a_hi", a, 24);
    check("reen_busy", bz, 0);
    check("reen_b_hi", b, 0);

    // Async reset in the middle of a dead-time.
    load(7, 1);
    wait_busy("rst_dead_start");
    #2 rst_n = 1'b0;
    #1;
    check("rstd_out_a", {31'd0, out_a}, 0);
    check("rstd_out_b", {31'd0, out_b}, 0);
    check("rstd_busy",  {31'd0, busy},  0);
    @(negedge clk);
    rst_n = 1'b1;
    measure(31, a, b, p, bz);
    check("rstd_run_a", a, 0);
    check("rstd_run_b", b, 0);
    check("rstd_run_per", p, 1);

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      load_n = ($urandom_range(0, 24) != 0);
      r = int'($urandom_range(0, 5));
      if (r == 0)      duty_in = 4'd0;
      else if (r == 1) duty_in = 4'd15;
      else             duty_in = NDUTY'($urandom_range(0, 15));
      dir = ($urandom_range(0, 1) == 1);
      if (en_n) en_n = ($urandom_range(0, 3) != 0);
      else      en_n = ($urandom_range(0, 399) == 0);
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
